gate_bist: RTL

//   Hardware self-test engine for the primitive gate set (nand/not/and/or/xor).

---
 rtl/gate_bist.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/gate_bist.sv
// Self-test engine for the primitive gate set: walks a/b through all four vectors and checks nand/not/and/or/xor.
// Define GATE_BIST_ERR_COUNT_EN to add the saturating err_count output.
module gate_bist #(
    parameter int SETTLE_CYCLES = 2,
    parameter int LOOPS         = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       nand_out,
    input  logic       not_out,
    input  logic       and_out,
    input  logic       or_out,
    input  logic       xor_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] fail_mask,
    output logic [1:0] fail_vec
`ifdef GATE_BIST_ERR_COUNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int LW = (LOOPS > 1) ? $clog2(LOOPS) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [LW-1:0] LOOP_LAST   = LW'(LOOPS - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

    state_t        state;
    logic [1:0]    vec;
    logic [SW-1:0] settle_cnt;
    logic [LW-1:0] loop_cnt;
    logic [4:0]    mism;
    logic [4:0]    mask_next;

    // Case inequality so an X/Z from a broken gate is reported as a mismatch.
    always_comb begin
        mism    = 5'b0;
        mism[0] = (nand_out !== ~(a & b));
        mism[1] = (not_out  !== ~a);
        mism[2] = (and_out  !== (a & b));
        mism[3] = (or_out   !== (a | b));
        mism[4] = (xor_out  !== (a ^ b));
    end

    assign mask_next = fail_mask | mism;

`ifdef GATE_BIST_ERR_COUNT_EN
    logic [2:0] mism_cnt;
    logic [8:0] err_sum;

    always_comb begin
        mism_cnt = 3'd0;
        for (int i = 0; i < 5; i++) mism_cnt = mism_cnt + {2'b0, mism[i]};
    end

    assign err_sum = {1'b0, err_count} + {6'b0, mism_cnt};

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_count <= 8'd0;
        else if (state == IDLE && start)
            err_count <= 8'd0;
        else if (state == CHECK)
            err_count <= err_sum[8] ? 8'hFF : err_sum[7:0];
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            vec        <= 2'd0;
            settle_cnt <= '0;
            loop_cnt   <= '0;
            a          <= 1'b0;
            b          <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_mask  <= 5'b0;
            fail_vec   <= 2'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    a <= 1'b0;
                    b <= 1'b0;
                    if (start) begin
                        fail_mask  <= 5'b0;
                        fail_vec   <= 2'd0;
                        pass       <= 1'b0;
                        vec        <= 2'd0;
                        loop_cnt   <= '0;
                        settle_cnt <= '0;
                        busy       <= 1'b1;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST)
                        state <= CHECK;
                    else
                        settle_cnt <= settle_cnt + 1'b1;
                end
                CHECK: begin
                    fail_mask  <= mask_next;
                    settle_cnt <= '0;
                    if (fail_mask == 5'b0 && mism != 5'b0)
                        fail_vec <= vec;
                    if (vec != 2'd3) begin
                        vec    <= vec + 2'd1;
                        {b, a} <= vec + 2'd1;
                        state  <= SETTLE;
                    end else if (loop_cnt != LOOP_LAST) begin
                        loop_cnt <= loop_cnt + 1'b1;
                        vec      <= 2'd0;
                        {b, a}   <= 2'd0;
                        state    <= SETTLE;
                    end else begin
                        // Result folds in this final CHECK via mask_next.
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        pass   <= (mask_next == 5'b0);
                        {b, a} <= 2'd0;
                        state  <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
